// File: rtl/riscv_pkg.sv
// Shared types for the fetch slice: XLEN, instruction word type, NOP,
// fetch FSM states and the buffered instruction entry.
package riscv_pkg;

   localparam int XLEN = 32;

   typedef logic [31:0] cmd_t;

   localparam cmd_t NOP = 32'h0000_0013;

   typedef enum logic [1:0] {
      F_RESET,
      F_REQ,
      F_WAIT,
      F_DROP
   } fetch_state_e;

   typedef struct packed {
      cmd_t            instr;
      logic [XLEN-1:0] pc;
   } fetch_entry_t;

   function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between fetch and decode: synchronous push/pop/flush,
// head is always visible, flush has priority over push and pop.
module fetch_fifo
   import riscv_pkg::*;
#(
   parameter int           DEPTH       = 2,
   parameter fetch_entry_t RESET_ENTRY = '0,
   localparam int          AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int          CW          = $clog2(DEPTH) + 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         push,
   input  fetch_entry_t push_data,
   input  logic         pop,
   input  logic         flush,
   output fetch_entry_t head,
   output logic [CW-1:0] count,
   output logic [CW-1:0] count_next
);

   fetch_entry_t  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CW'(DEPTH)) || do_pop);
   assign head    = mem[rd_ptr];

   always_comb begin
      if (flush) begin
         count_next = '0;
      end else begin
         count_next = count + CW'(do_push) - CW'(do_pop);
      end
   end

   // Entries reset to a known NOP so the head output is defined out of reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= RESET_ENTRY;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         count <= count_next;
         if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (do_push) begin
               mem[wr_ptr] <= push_data;
               wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
               rd_ptr <= rd_ptr + AW'(1);
            end
         end
      end
   end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: one-outstanding-request memory FSM with redirect
// handling, feeding decode through a small instruction buffer.
module instr_fetch
   import riscv_pkg::*;
#(
   parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter int              FIFO_DEPTH   = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req_o,
   output logic [XLEN-1:0] imem_addr_o,
   input  logic            imem_gnt_i,
   input  logic            imem_rvalid_i,
   input  logic [31:0]     imem_rdata_i,
   input  logic            redirect_i,
   input  logic [XLEN-1:0] redirect_pc_i,
   output cmd_t            instr_o,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus4_o,
   output logic            valid_o,
   input  logic            ready_i,
   output fetch_state_e    dbg_state
);

   localparam int           CW          = $clog2(FIFO_DEPTH) + 1;
   localparam fetch_entry_t RESET_ENTRY = '{instr: NOP, pc: RESET_VECTOR};

   fetch_state_e    state;
   fetch_state_e    state_d;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pc_d;
   logic [XLEN-1:0] issued_pc;
   logic [XLEN-1:0] target;
   logic            granted;
   logic            push;
   logic            req_d;
   fetch_entry_t    push_data;
   fetch_entry_t    head;
   logic [CW-1:0]   count;
   logic [CW-1:0]   count_next;

   assign granted   = imem_req_o && imem_gnt_i;
   assign target    = word_align(redirect_pc_i);
   assign push_data = '{instr: imem_rdata_i, pc: issued_pc};
   assign dbg_state = state;

   always_comb begin
      state_d = state;
      pc_d    = pc;
      push    = 1'b0;
      unique case (state)
         F_RESET: begin
            state_d = F_REQ;
            if (redirect_i) pc_d = target;
         end
         F_REQ: begin
            if (redirect_i) begin
               pc_d    = target;
               state_d = granted ? F_DROP : F_REQ;
            end else if (granted) begin
               pc_d    = pc + XLEN'(4);
               state_d = F_WAIT;
            end
         end
         F_WAIT: begin
            if (redirect_i) begin
               pc_d    = target;
               state_d = imem_rvalid_i ? F_REQ : F_DROP;
            end else if (imem_rvalid_i) begin
               push    = 1'b1;
               state_d = F_REQ;
            end
         end
         F_DROP: begin
            if (redirect_i) pc_d = target;
            // The stale response retires the outstanding request even if a
            // new redirect lands in the same cycle, so no response is awaited.
            if (imem_rvalid_i) state_d = F_REQ;
         end
      endcase
   end

   assign req_d = (state_d == F_REQ) && (count_next < CW'(FIFO_DEPTH));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= F_RESET;
         pc          <= RESET_VECTOR;
         issued_pc   <= RESET_VECTOR;
         imem_req_o  <= 1'b0;
         imem_addr_o <= RESET_VECTOR;
      end else begin
         state       <= state_d;
         pc          <= pc_d;
         imem_req_o  <= req_d;
         imem_addr_o <= pc_d;
         if ((state == F_REQ) && granted) issued_pc <= pc;
      end
   end

   fetch_fifo #(
      .DEPTH       (FIFO_DEPTH),
      .RESET_ENTRY (RESET_ENTRY)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .push       (push),
      .push_data  (push_data),
      .pop        (ready_i),
      .flush      (redirect_i),
      .head       (head),
      .count      (count),
      .count_next (count_next)
   );

   assign valid_o    = (count != '0);
   assign instr_o    = head.instr;
   assign pc_o       = head.pc;
   assign pc_plus4_o = head.pc + XLEN'(4);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus random traffic, checked
// every cycle against a transaction-level fetch model with an expected queue.
module tb_instr_fetch;
   import riscv_pkg::*;

   localparam int          DEPTH = 2;
   localparam logic [31:0] RV    = 32'h0000_0000;

   logic         clk = 1'b0;
   logic         rst_n = 1'b1;
   logic         imem_req_o;
   logic [31:0]  imem_addr_o;
   logic         imem_gnt_i = 1'b0;
   logic         imem_rvalid_i = 1'b0;
   logic [31:0]  imem_rdata_i = '0;
   logic         redirect_i = 1'b0;
   logic [31:0]  redirect_pc_i = '0;
   cmd_t         instr_o;
   logic [31:0]  pc_o;
   logic [31:0]  pc_plus4_o;
   logic         valid_o;
   logic         ready_i = 1'b0;
   fetch_state_e dbg_state;

   instr_fetch #(.RESET_VECTOR(RV), .FIFO_DEPTH(DEPTH)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .imem_req_o    (imem_req_o),
      .imem_addr_o   (imem_addr_o),
      .imem_gnt_i    (imem_gnt_i),
      .imem_rvalid_i (imem_rvalid_i),
      .imem_rdata_i  (imem_rdata_i),
      .redirect_i    (redirect_i),
      .redirect_pc_i (redirect_pc_i),
      .instr_o       (instr_o),
      .pc_o          (pc_o),
      .pc_plus4_o    (pc_plus4_o),
      .valid_o       (valid_o),
      .ready_i       (ready_i),
      .dbg_state     (dbg_state)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: expected buffer contents {instr, pc}, next fetch
   // address, and the single outstanding request (stale once redirected).
   logic [63:0] exp_q[$];
   logic [31:0] pop_log[$];
   logic [31:0] m_pc = RV;
   logic [31:0] pend_addr = '0;
   bit          pending = 0;
   bit          stale = 0;
   bit          boot = 1;

   function automatic logic [31:0] mem_word(input logic [31:0] addr);
      return (addr * 32'h9E37_79B1) ^ 32'h00C0_FFEE;
   endfunction

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Called at posedge+1 with this cycle's inputs applied; compares outputs,
   // advances the model by this cycle's events, then steps one clock.
   task automatic cycle();
      bit          exp_req;
      logic [63:0] head;
      exp_req = !boot && !pending && (exp_q.size() < DEPTH);
      check("req", imem_req_o, 32'(exp_req));
      if (exp_req) check("addr", imem_addr_o, m_pc);
      check("valid", valid_o, 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
         head = exp_q[0];
         check("instr", instr_o, head[63:32]);
         check("pc", pc_o, head[31:0]);
         check("pc4", pc_plus4_o, head[31:0] + 32'd4);
         if (ready_i) begin
            void'(exp_q.pop_front());
            pop_log.push_back(head[31:0]);
         end
      end
      if (redirect_i) begin
         exp_q.delete();
         m_pc = {redirect_pc_i[31:2], 2'b00};
         if (exp_req && imem_gnt_i) begin
            pending = 1;
            stale   = 1;
         end else if (pending && imem_rvalid_i) begin
            pending = 0;
         end else if (pending) begin
            stale = 1;
         end
      end else if (exp_req && imem_gnt_i) begin
         pending   = 1;
         stale     = 0;
         pend_addr = m_pc;
         m_pc      = m_pc + 32'd4;
      end else if (pending && imem_rvalid_i) begin
         if (!stale) exp_q.push_back({imem_rdata_i, pend_addr});
         pending = 0;
      end
      boot = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic set_in(input bit gnt, input bit rv, input bit rdy, input bit redir,
                         input logic [31:0] rpc);
      imem_gnt_i    = gnt;
      imem_rvalid_i = rv;
      imem_rdata_i  = mem_word(pend_addr);
      ready_i       = rdy;
      redirect_i    = redir;
      redirect_pc_i = rpc;
   endtask

   task automatic drive(input int gnt_pct, input int rv_pct, input int rdy_pct);
      set_in(int'($urandom_range(99)) < gnt_pct,
             pending && (int'($urandom_range(99)) < rv_pct),
             int'($urandom_range(99)) < rdy_pct, 1'b0, '0);
   endtask

   task automatic run(input int n, input int g, input int r, input int d);
      repeat (n) begin
         drive(g, r, d);
         cycle();
      end
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      set_in(0, 0, 0, 0, '0);
      #1;
      check("rst_req", imem_req_o, 32'd0);
      check("rst_addr", imem_addr_o, RV);
      check("rst_valid", valid_o, 32'd0);
      check("rst_instr", instr_o, 32'h0000_0013);
      check("rst_pc", pc_o, RV);
      check("rst_pc4", pc_plus4_o, RV + 32'd4);
      check("rst_state", 32'(dbg_state), 32'(F_RESET));
      exp_q.delete();
      pop_log.delete();
      pending = 0;
      stale   = 0;
      boot    = 1;
      m_pc    = RV;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      #3;
      apply_reset();

      // Streaming with gnt=1, 1-cycle rvalid, ready=1: 0, 4, 8 in order.
      run(9, 100, 100, 100);
      check("seq_n", 32'(pop_log.size()), 32'd3);
      check("seq0", pop_log[0], 32'd0);
      check("seq1", pop_log[1], 32'd4);
      check("seq2", pop_log[2], 32'd8);

      // Decode stalled: buffer fills with 12 and 16, then fetch stops.
      run(10, 100, 100, 0);
      check("stall_req", imem_req_o, 32'd0);
      check("stall_valid", valid_o, 32'd1);
      check("stall_instr", instr_o, mem_word(32'd12));
      check("stall_pc", pc_o, 32'd12);
      n = 0;
      for (int i = 0; i < 6; i++) begin
         drive(0, 100, 100);
         if (valid_o) n++;
         cycle();
      end
      check("stall_cnt", 32'(n), 32'd2);

      // Grant withheld: request and address hold, advance only after grant.
      for (int i = 0; i < 5; i++) begin
         set_in(0, 0, 0, 0, '0);
         check("hold_req", imem_req_o, 32'd1);
         check("hold_addr", imem_addr_o, 32'd20);
         cycle();
      end
      set_in(1, 0, 0, 0, '0);
      cycle();
      set_in(0, 1, 0, 0, '0);
      cycle();
      check("adv_addr", imem_addr_o, 32'd24);

      // Redirect while waiting: stale word dropped, refetch at 0x100.
      set_in(1, 0, 0, 0, '0);
      cycle();
      set_in(0, 0, 0, 1, 32'h0000_0103);
      check("rdw_pre_valid", valid_o, 32'd1);
      cycle();
      check("rdw_valid", valid_o, 32'd0);
      set_in(0, 1, 0, 0, '0);
      cycle();
      check("rdw_req", imem_req_o, 32'd1);
      check("rdw_addr", imem_addr_o, 32'h0000_0100);

      // Redirect coinciding with rvalid: data never shown, refetch target.
      set_in(1, 0, 1, 0, '0);
      cycle();
      set_in(0, 1, 1, 1, 32'h0000_2000);
      cycle();
      check("rdv_valid", valid_o, 32'd0);
      check("rdv_req", imem_req_o, 32'd1);
      check("rdv_addr", imem_addr_o, 32'h0000_2000);
      pop_log.delete();
      run(4, 100, 100, 100);
      check("rdv_first", pop_log[0], 32'h0000_2000);

      // Address wrap at the top of memory, then reset in the middle of a wait.
      set_in(0, 0, 1, 1, 32'hFFFF_FFFE);
      cycle();
      set_in(0, 1, 1, 0, '0);
      cycle();
      check("wrap_pre", imem_addr_o, 32'hFFFF_FFFC);
      set_in(1, 0, 0, 0, '0);
      cycle();
      set_in(0, 1, 0, 0, '0);
      cycle();
      check("wrap_req", imem_req_o, 32'd1);
      check("wrap_addr", imem_addr_o, 32'd0);
      check("wrap_pc4", pc_plus4_o, 32'd0);
      set_in(1, 0, 0, 0, '0);
      cycle();
      apply_reset();

      // Late response after reset is ignored.
      set_in(0, 1, 0, 0, '0);
      imem_rdata_i = 32'hDEAD_BEEF;
      cycle();
      set_in(0, 1, 0, 0, '0);
      imem_rdata_i = 32'hDEAD_BEEF;
      cycle();
      check("late_rv", valid_o, 32'd0);
      run(6, 100, 100, 100);

      // Random traffic with redirects and one mid-run reset.
      for (int i = 0; i < 3000; i++) begin
         drive(70, 60, 70);
         if ($urandom_range(99) < 4) begin
            redirect_i    = 1'b1;
            redirect_pc_i = $urandom_range(1) ? (32'hFFFF_FFF0 | 32'($urandom_range(15)))
                                              : $urandom();
         end
         cycle();
         if (i == 1500) apply_reset();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 2, the instruction buffer depth (power of two, >=2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, the asynchronous active-low reset.
REQ-005 The block SHALL have port imem_req_o, output, 1, the instruction memory request.
REQ-006 The block SHALL have port imem_addr_o, output, XLEN, the request address, word aligned.
REQ-007 The block SHALL have port imem_gnt_i, input, 1, the memory accepting the request this cycle.
REQ-008 The block SHALL have port imem_rvalid_i, input, 1, read data valid.
REQ-009 The block SHALL have port imem_rdata_i, input, 32, the fetched instruction word.
REQ-010 The block SHALL have port redirect_i, input, 1, the branch/jump redirect strobe.
REQ-011 The block SHALL have port redirect_pc_i, input, XLEN, the redirect target, with bits [1:0] ignored.
REQ-012 The block SHALL have port instr_o, output, cmd_t, the instruction to decode and immediate extraction.
REQ-013 The block SHALL have port pc_o, output, XLEN, the address of instr_o.
REQ-014 The block SHALL have port pc_plus4_o, output, XLEN, equal to pc_o + 4.
REQ-015 The block SHALL have port valid_o, output, 1, meaning instr_o/pc_o are valid.
REQ-016 The block SHALL have port ready_i, input, 1, meaning decode accepts the instruction this cycle.

Function
REQ-017 The FSM SHALL have states F_RESET, F_REQ, F_WAIT and F_DROP.
REQ-018 From F_RESET, the FSM SHALL move to F_REQ on the first clock after reset is released, with no request issued in F_RESET.
REQ-019 In F_REQ, imem_req_o SHALL be 1 iff buffer count < FIFO_DEPTH, with imem_addr_o = fetch PC.
REQ-020 While imem_req_o=1 and imem_gnt_i=0, req and addr SHALL stay stable unless a redirect occurs.
REQ-021 On F_REQ with req&gnt, the fetch PC SHALL become PC+4 (mod 2^XLEN, wrapping from 32'hFFFF_FFFC to 0), and the FSM SHALL go to F_WAIT.
REQ-022 At most one request SHALL be outstanding, with imem_req_o=0 in F_WAIT and F_DROP.
REQ-023 In F_WAIT, rvalid SHALL push {rdata, issued PC} into the buffer and the FSM SHALL return to F_REQ.
REQ-024 A redirect in F_REQ without gnt SHALL load fetch PC = {redirect_pc_i[XLEN-1:2],2'b00}, keep the FSM in F_REQ, and move req/addr to the new PC next cycle.
REQ-025 A redirect coinciding with gnt in F_REQ, or occurring in F_WAIT without rvalid, SHALL load the PC and move the FSM to F_DROP.
REQ-026 A redirect coinciding with rvalid in F_WAIT SHALL discard the data, load the PC and move the FSM to F_REQ.
REQ-027 In F_DROP, rvalid data SHALL be discarded and the FSM SHALL go to F_REQ; a redirect in F_DROP SHALL reload the PC and keep the FSM in F_DROP.
REQ-028 Any redirect SHALL clear the buffer in the same edge, giving valid_o=0 the next cycle; redirect has priority over push and pop.
REQ-029 Push-to-output latency SHALL be 1 cycle: rvalid at cycle T gives valid_o=1 at T+1 if the buffer was empty.
REQ-030 A pop SHALL occur on valid_o&ready_i; instr_o/pc_o SHALL hold while valid_o&!ready_i.
REQ-031 Simultaneous push and pop SHALL leave the count unchanged and preserve order.
REQ-032 With a full buffer, no request SHALL be issued; the block SHALL sustain one instruction per 2 cycles with gnt=1 and 1-cycle rvalid.

Reset
REQ-033 On rst_n=0, asynchronously: state F_RESET, fetch PC=RESET_VECTOR, count=0, imem_req_o=0, imem_addr_o=RESET_VECTOR, valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=RESET_VECTOR, pc_plus4_o=RESET_VECTOR+4.
REQ-034 Reset mid-transaction SHALL abandon the outstanding request, and a late rvalid after reset SHALL be ignored until the first post-reset grant.

Structure
REQ-035 XLEN, cmd_t, the NOP constant and the fetch state enum fetch_state_e SHALL live in riscv_pkg.
REQ-036 The buffer SHALL be a sub-module fetch_fifo (synchronous push/pop/flush, count output), and instr_fetch SHALL hold the FSM and PC.

Verification
REQ-037 The bench SHALL check: reset release, gnt=1, rvalid 1 cycle later, ready=1 -> addresses 0,4,8; valid_o with pc_o 0,4,8 in order.
REQ-038 The bench SHALL check: ready_i=0 for 10 cycles -> exactly 2 instructions buffered, imem_req_o=0, instr_o stable.
REQ-039 The bench SHALL check: redirect to 32'h0000_0103 in F_WAIT -> the stale rvalid word is dropped, the next request addr is 32'h0000_0100, and valid_o=0 the next cycle.
REQ-040 The bench SHALL check: redirect coinciding with rvalid -> the data is never presented, and the next request is the redirect PC.
REQ-041 The bench SHALL check: gnt held 0 for 5 cycles -> req and addr stable; the PC advances only after gnt.
REQ-042 The bench SHALL check: PC 32'hFFFF_FFFC granted -> next addr 0; rst_n pulsed mid-F_WAIT -> all outputs take their REQ-033 values immediately.
